// File: rtl/scanline_term_pkg.sv
// Shared types and helpers for the scanline term sequencer.
// The optional term check is enabled with the SCANLINE_TERM_CHECK_EN macro.
package scanline_term_pkg;

  function automatic int term_w(input int dw_integer, input int dw_fraction,
                                input int dw_keep_fraction);
    return dw_integer + dw_fraction - dw_keep_fraction + 1;
  endfunction

  // 2.0 expressed in term units for a given number of kept fraction bits.
  function automatic int term_step(input int dw_keep_fraction);
    return 2 << dw_keep_fraction;
  endfunction

  localparam int TERM_W    = term_w(16, 8, 4);
  localparam int TERM_STEP = term_step(4);

  typedef logic signed [TERM_W-1:0] term_t;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_CONFIG     = 3'd1;
  localparam state_t ST_WAIT_TERMS = 3'd2;
  localparam state_t ST_ACK        = 3'd3;
  localparam state_t ST_STREAM     = 3'd4;

endpackage

// File: rtl/scanline_term_sequencer_serializer.sv
// Capture buffer for one scan point and the serial valid/ready term stream.
// Related macro: SCANLINE_TERM_CHECK_EN (handled in the top, not here).
module term_stream_serializer
  import scanline_term_pkg::*;
#(
  parameter int TERM_W       = 21,
  parameter int NUM_ELEMENTS = 64,
  parameter int EW           = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_load,
  input  logic [NUM_ELEMENTS*TERM_W-1:0] i_terms,
  input  logic                           i_launch,
  input  logic                           i_ready,
  output logic                           o_busy,
  output logic signed [TERM_W-1:0]       o_term,
  output logic [EW-1:0]                  o_elem,
  output logic                           o_last_beat
);

  logic signed [TERM_W-1:0] r_buf [NUM_ELEMENTS];
  logic [EW-1:0]            r_elem;
  logic                     r_valid;
  logic                     w_fire;

  assign w_fire      = r_valid & i_ready;
  assign o_last_beat = w_fire && (r_elem == EW'(NUM_ELEMENTS - 1));
  assign o_busy      = r_valid;
  assign o_elem      = r_elem;
  assign o_term      = r_buf[r_elem];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_elem  <= '0;
      // NOTE: the buffer is explicitly cleared so out_term reads 0 after reset;
      // this costs a reset on every buffer bit rather than a plain RAM.
      for (int n = 0; n < NUM_ELEMENTS; n++) r_buf[n] <= '0;
    end else begin
      if (i_load) begin
        for (int n = 0; n < NUM_ELEMENTS; n++) r_buf[n] <= i_terms[n*TERM_W +: TERM_W];
        r_elem <= '0;
      end
      if (i_launch)         r_valid <= 1'b1;
      else if (o_last_beat) r_valid <= 1'b0;
      if (w_fire) r_elem <= o_last_beat ? '0 : r_elem + 1'b1;
    end
  end

endmodule

// File: rtl/scanline_term_sequencer.sv
// Scanline term sequencer: configures the term generator, captures each point's
// terms and streams them per element. Optional macro: SCANLINE_TERM_CHECK_EN.
module scanline_term_sequencer
  import scanline_term_pkg::*;
#(
  parameter int DW_INTEGER               = 16,
  parameter int DW_FRACTION              = 8,
  parameter int DW_INC_AND_COMP_FRACTION = 4,
  parameter int DW_INPUT                 = 8,
  parameter int DW_ANGLE                 = 8,
  parameter int NUM_ELEMENTS             = 64,
  parameter int DW_POINTS                = 10,
  localparam int TERM_W = term_w(DW_INTEGER, DW_FRACTION, DW_INC_AND_COMP_FRACTION),
  localparam int EW     = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DW_INPUT-1:0]            r_0_in,
  input  logic [DW_ANGLE-1:0]            angle_in,
  input  logic [DW_POINTS-1:0]           num_points,
  output logic                           configure,
  output logic [DW_INPUT-1:0]            r_0,
  output logic [DW_ANGLE-1:0]            angle,
  input  logic [NUM_ELEMENTS*TERM_W-1:0] terms_in,
  input  logic                           terms_ready,
  input  logic                           done_configuring,
  output logic                           ack,
  output logic                           final_scanpoint,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [TERM_W-1:0]       out_term,
  output logic [EW-1:0]                  out_elem,
  output logic [DW_POINTS-1:0]           out_point,
  output logic                           out_last,
  output logic                           busy,
  output logic                           scan_done,
  output logic                           term_err
);

  state_t               r_state;
  logic [DW_INPUT-1:0]  r_r0;
  logic [DW_ANGLE-1:0]  r_angle;
  logic [DW_POINTS-1:0] r_point;
  logic [DW_POINTS-1:0] r_last_point;
  logic                 r_configure;
  logic                 r_ack;
  logic                 r_final;
  logic                 r_scan_done;
  logic                 w_capture;
  logic                 w_accept;
  logic                 w_last_beat;
  logic                 w_stream_busy;

  assign w_accept  = (r_state == ST_IDLE) && start;
  // Capture only happens in WAIT_TERMS, so a stale ready after ack is never used.
  assign w_capture = (r_state == ST_WAIT_TERMS) && terms_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_r0         <= '0;
      r_angle      <= '0;
      r_point      <= '0;
      r_last_point <= '0;
      r_configure  <= 1'b0;
      r_ack        <= 1'b0;
      r_final      <= 1'b0;
      r_scan_done  <= 1'b0;
    end else begin
      r_configure <= 1'b0;
      r_ack       <= 1'b0;
      r_final     <= 1'b0;
      r_scan_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_r0         <= r_0_in;
          r_angle      <= angle_in;
          r_last_point <= (num_points == '0) ? '0 : num_points - 1'b1;
          r_point      <= '0;
          r_configure  <= 1'b1;
          r_state      <= ST_CONFIG;
        end
        ST_CONFIG: r_state <= ST_WAIT_TERMS;
        ST_WAIT_TERMS: if (terms_ready) begin
          r_ack   <= 1'b1;
          r_final <= (r_point == r_last_point);
          r_state <= ST_ACK;
        end
        ST_ACK: r_state <= ST_STREAM;
        ST_STREAM: if (w_last_beat) begin
          if (r_point == r_last_point) begin
            r_scan_done <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_point <= r_point + 1'b1;
            r_state <= ST_WAIT_TERMS;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  term_stream_serializer #(
    .TERM_W       (TERM_W),
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .EW           (EW)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_capture),
    .i_terms     (terms_in),
    .i_launch    (r_state == ST_ACK),
    .i_ready     (out_ready),
    .o_busy      (w_stream_busy),
    .o_term      (out_term),
    .o_elem      (out_elem),
    .o_last_beat (w_last_beat)
  );

  assign configure       = r_configure;
  assign r_0             = r_r0;
  assign angle           = r_angle;
  assign ack             = r_ack;
  assign final_scanpoint = r_final;
  assign out_valid       = w_stream_busy;
  assign out_point       = r_point;
  assign out_last        = w_stream_busy && (out_elem == EW'(NUM_ELEMENTS - 1)) &&
                           (r_point == r_last_point);
  assign busy            = (r_state != ST_IDLE);
  assign scan_done       = r_scan_done;

`ifdef SCANLINE_TERM_CHECK_EN
  localparam logic signed [TERM_W-1:0] TERM_STEP_W = TERM_W'(term_step(DW_INC_AND_COMP_FRACTION));

  logic signed [TERM_W-1:0] r_prev [NUM_ELEMENTS];
  logic                     r_term_err;
  logic                     w_step_err;
  logic                     w_check_err;

  always_comb begin
    // NOTE: default first so the loop below cannot infer a latch.
    w_step_err = 1'b0;
    for (int n = 0; n < NUM_ELEMENTS; n++) begin
      if (terms_in[n*TERM_W +: TERM_W] != TERM_W'(r_prev[n] + TERM_STEP_W)) w_step_err = 1'b1;
    end
  end

  // Point 0 has no predecessor; there the generator must report configured.
  assign w_check_err = (r_point == '0) ? !done_configuring : w_step_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_term_err <= 1'b0;
      for (int n = 0; n < NUM_ELEMENTS; n++) r_prev[n] <= '0;
    end else begin
      if (w_accept)                     r_term_err <= 1'b0;
      else if (w_capture && w_check_err) r_term_err <= 1'b1;
      if (w_capture) begin
        for (int n = 0; n < NUM_ELEMENTS; n++) r_prev[n] <= terms_in[n*TERM_W +: TERM_W];
      end
    end
  end

  assign term_err = r_term_err;
`else
  logic w_unused_check;
  assign w_unused_check = done_configuring ^ w_accept;
  assign term_err       = 1'b0;
`endif

endmodule

// File: tb/tb_scanline_term_sequencer.sv
// Randomized bench for scanline_term_sequencer with a point/element scoreboard.
// Term-check expectations follow the SCANLINE_TERM_CHECK_EN macro.
module tb_scanline_term_sequencer;

  localparam int TW = 21;
  localparam int NE = 64;
  localparam int PW = 10;
`ifdef SCANLINE_TERM_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [7:0]         r_0_in = '0;
  logic [7:0]         angle_in = '0;
  logic [PW-1:0]      num_points = '0;
  logic               configure;
  logic [7:0]         r_0;
  logic [7:0]         angle;
  logic [NE*TW-1:0]   terms_in = '0;
  logic               terms_ready = 1'b0;
  logic               done_configuring = 1'b1;
  logic               ack;
  logic               final_scanpoint;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [TW-1:0] out_term;
  logic [5:0]         out_elem;
  logic [PW-1:0]      out_point;
  logic               out_last;
  logic               busy;
  logic               scan_done;
  logic               term_err;

  scanline_term_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .r_0_in(r_0_in), .angle_in(angle_in),
    .num_points(num_points), .configure(configure), .r_0(r_0), .angle(angle),
    .terms_in(terms_in), .terms_ready(terms_ready), .done_configuring(done_configuring),
    .ack(ack), .final_scanpoint(final_scanpoint), .out_valid(out_valid),
    .out_ready(out_ready), .out_term(out_term), .out_elem(out_elem),
    .out_point(out_point), .out_last(out_last), .busy(busy), .scan_done(scan_done),
    .term_err(term_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [TW-1:0] term;
    int                   elem;
    int                   point;
    logic                 last;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, acks_seen = 0, beats_seen = 0, done_seen = 0, last_beat_cyc = -10;
  int exp_points = 1, base_mode = 0, rdy_mode = 0, ordy_mode = 0, inject = 0, gk = 0;
  int cur_r0 = 0, cur_ang = 0;
  logic signed [TW-1:0] last_term = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Generator behaviour: base pattern plus 2.0 per point, optional fault at k=1/elem 7.
  function automatic int model_term(input int e, input int k);
    int b;
    b = (base_mode != 0) ? 1000 + e : 5210;
    return b + 32 * k - ((inject != 0 && k == 1 && e == 7) ? 1 : 0);
  endfunction

  initial begin : stub
    forever begin
      @(posedge clk); #1;
      if (configure) gk = 0;
      else if (ack) gk++;
      for (int e = 0; e < NE; e++) terms_in[e*TW +: TW] = TW'(model_term(e, gk));
      terms_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
      case (ordy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin : compare
    logic prev_stall, prev_ack;
    logic [63:0] held;
    beat_t b;
    prev_stall = 1'b0; prev_ack = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_stall = 1'b0; prev_ack = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_term, out_elem, out_point}, held);
      end
      if (ack) begin
        check("ack_back_to_back", prev_ack, 0);
        check("ack_during_stream", out_valid, 0);
        check("final_scanpoint", final_scanpoint, acks_seen == exp_points - 1);
        check("term_err_at_ack", term_err, CHECK_EN && inject != 0 && acks_seen >= 1);
        acks_seen++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          b = exp_q.pop_front();
          check("beat_term", out_term, b.term);
          check("beat_elem", out_elem, b.elem);
          check("beat_point", out_point, b.point);
          check("beat_last", out_last, b.last);
        end
        beats_seen++;
        last_beat_cyc = cyc;
        last_term = out_term;
      end
      if (scan_done) begin
        check("scan_done_timing", cyc, last_beat_cyc + 1);
        done_seen++;
      end
      prev_stall = out_valid && !out_ready;
      held = {out_term, out_elem, out_point};
      prev_ack = ack;
    end
  end

  task automatic begin_scan(input int r0, input int ang, input int np, input int bmode,
                            input int rmode, input int omode, input int inj);
    beat_t b;
    int p;
    p = (np == 0) ? 1 : np;
    base_mode = bmode; rdy_mode = rmode; ordy_mode = omode; inject = inj;
    exp_q.delete();
    for (int k = 0; k < p; k++)
      for (int e = 0; e < NE; e++) begin
        b.term = TW'(model_term(e, k)); b.elem = e; b.point = k;
        b.last = (k == p - 1) && (e == NE - 1);
        exp_q.push_back(b);
      end
    exp_points = p; acks_seen = 0; beats_seen = 0; done_seen = 0;
    cur_r0 = r0; cur_ang = ang;
    @(posedge clk); #1;
    start = 1'b1; r_0_in = 8'(r0); angle_in = 8'(ang); num_points = PW'(np);
    @(posedge clk); #1;
    start = 1'b0; r_0_in = 8'($urandom); angle_in = 8'($urandom); num_points = PW'($urandom);
  endtask

  task automatic finish_scan(input bit noise);
    int c;
    for (c = 0; c < 20000 && done_seen == 0; c++) begin
      @(posedge clk); #1;
      start = (noise && exp_q.size() > 4) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (noise) num_points = PW'($urandom_range(1, 9));
    end
    start = 1'b0;
    check("scan_timeout", done_seen != 0, 1);
    check("ack_count", acks_seen, exp_points);
    check("beat_count", beats_seen, exp_points * NE);
    check("queue_empty", exp_q.size(), 0);
    check("r_0_hold", r_0, cur_r0);
    check("angle_hold", angle, cur_ang);
    check("busy_after_done", busy, 0);
    check("term_err_end", term_err, CHECK_EN && inject != 0);
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {configure, r_0, angle, ack, final_scanpoint, out_valid, out_term,
          out_elem, out_point, out_last, busy, scan_done, term_err}, 0);
    rst = 1'b1;

    // Scanline 1: fixed terms, hand-computed latencies and values.
    begin_scan(10, 90, 3, 0, 0, 0, 0);
    check("cfg_pulse", configure, 1);
    check("cfg_r0", r_0, 10);
    check("cfg_angle", angle, 90);
    check("cfg_busy", busy, 1);
    @(posedge clk); #1;
    check("cfg_one_cycle", configure, 0);
    @(posedge clk); #1;
    check("first_ack", ack, 1);
    check("first_final", final_scanpoint, 0);
    @(posedge clk); #1;
    check("first_valid", out_valid, 1);
    check("first_term", out_term, 5210);
    check("first_elem", out_elem, 0);
    finish_scan(1'b0);
    check("beats_192", beats_seen, 192);
    check("last_term_5274", last_term, 5274);

    // Ramp terms with out_ready toggling 1-0-1-0.
    begin_scan($urandom_range(0, 255), $urandom_range(0, 180), 2, 1, 1, 1, 0);
    finish_scan(1'b0);

    // Ready held high, random back-pressure, starts while busy.
    begin_scan($urandom_range(0, 255), $urandom_range(0, 180), 4, 1, 0, 2, 0);
    finish_scan(1'b1);

    // Reset mid-stream at beat 20, then a clean scanline.
    begin_scan(33, 45, 3, 0, 1, 0, 0);
    for (int c = 0; c < 2000 && beats_seen < 20; c++) begin
      @(posedge clk); #1;
    end
    check("reach_beat_20", beats_seen >= 20, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midscan_reset_outputs", {configure, r_0, angle, ack, final_scanpoint, out_valid,
          out_term, out_elem, out_point, out_last, busy, scan_done, term_err}, 0);
    exp_q.delete();
    rst = 1'b1;
    begin_scan($urandom_range(0, 255), $urandom_range(0, 180), 2, 0, 1, 2, 0);
    finish_scan(1'b0);

    // num_points = 0 behaves as a single point.
    begin_scan(7, 12, 0, 1, 1, 2, 0);
    finish_scan(1'b0);
    check("np0_acks", acks_seen, 1);
    check("np0_beats", beats_seen, 64);

    // Faulty step at k=1, element 7; flag clears on the next accepted start.
    begin_scan(20, 30, 3, 0, 1, 0, 1);
    finish_scan(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("term_err_held", term_err, CHECK_EN);
    begin_scan(21, 31, 2, 0, 0, 2, 0);
    check("term_err_cleared", term_err, 0);
    finish_scan(1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/scanline_term_sequencer.md
Name: scanline_term_sequencer

Overview:
- Consumer and initiator side of the per-element comparator-term interface (configure / ready / ack / final_scanpoint).
- On a scanline start request, it configures the term generator and captures all NUM_ELEMENTS terms for each scan point.
- It acks each point as soon as its terms are captured, so the generator computes point k+1 while point k is streamed out.
- Terms leave serially, one element per beat, to the downstream per-element delay/comparator datapath over a valid/ready stream.

Parameters:
- DW_INTEGER, 16, integer bits of term arithmetic
- DW_FRACTION, 8, fraction bits of term arithmetic
- DW_INC_AND_COMP_FRACTION, 4, fraction bits kept in terms
- DW_INPUT, 8, R_0 width
- DW_ANGLE, 8, angle width (degrees)
- NUM_ELEMENTS, 64, transducer elements
- DW_POINTS, 10, scan-point counter width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- start  input  1  scanline request; sampled only in IDLE
- r_0_in  input  DW_INPUT  scanline R_0; latched on accepted start
- angle_in  input  DW_ANGLE  scanline angle; latched on accepted start
- num_points  input  DW_POINTS  points per scanline (0 treated as 1); latched on accepted start
- configure  output  1  generator configure pulse
- r_0  output  DW_INPUT  latched R_0 to generator
- angle  output  DW_ANGLE  latched angle to generator
- terms_in  input  TERM_W x NUM_ELEMENTS  signed generator terms
- terms_ready  input  1  generator result ready
- done_configuring  input  1  generator configured flag
- ack  output  1  one-cycle capture acknowledge
- final_scanpoint  output  1  high with ack of the last point
- out_valid  output  1  stream beat valid
- out_ready  input  1  downstream accept
- out_term  output  TERM_W  signed term of the current element
- out_elem  output  6  element index 0..NUM_ELEMENTS-1
- out_point  output  DW_POINTS  point index k
- out_last  output  1  last element of the last point
- busy  output  1  not IDLE
- scan_done  output  1  one-cycle pulse after the final beat
- term_err  output  1  sticky check flag (see Optional Feature)

Behaviour:
- TERM_W = DW_INTEGER + DW_FRACTION - DW_INC_AND_COMP_FRACTION + 1 (21 at defaults).
- Reset (rst = 0, synchronous):
  - State goes to IDLE.
  - All outputs go to 0.
  - Capture buffer, point and element counters are cleared.
  - Reset mid-scanline abandons the scanline immediately; no ack is issued.
- States:
  - IDLE: when start is high, latch r_0_in, angle_in and num_points, then go to CONFIG.
  - CONFIG: drive configure high for exactly one cycle, then go to WAIT_TERMS.
  - WAIT_TERMS: when terms_ready is high, capture all terms_in into the buffer in one cycle and go to ACK.
  - ACK: drive ack high for exactly 1 cycle. final_scanpoint = (k == num_points-1) in that same cycle. Then go to STREAM.
  - STREAM: out_valid is held high. Each out_valid & out_ready beat advances out_elem. After beat NUM_ELEMENTS-1:
    - if k was the last point, go to IDLE and pulse scan_done;
    - otherwise increment k and go to WAIT_TERMS.
- terms_ready is ignored in the cycle after ack, because generator ready is stale then. The next point is never captured before the current point's stream completes.
- out_term, out_elem and out_point stay stable while out_valid & !out_ready.
- out_last = out_valid & (out_elem == NUM_ELEMENTS-1) & last point.
- done_configuring is informational only; it is used by the check feature.
- start while busy is ignored.
- Latency:
  - start to configure: 1 cycle.
  - terms_ready to ack: 1 cycle.
  - ack to first out_valid: 1 cycle.
  - One point with out_ready held high: NUM_ELEMENTS + 2 cycles from capture.

Optional Feature:
- Macro: SCANLINE_TERM_CHECK_EN
- Defined:
  - For every point k > 0, each captured term must equal the previous point's term for the same element + 2.0, i.e. +(2 << DW_INC_AND_COMP_FRACTION) = +32.
  - At point 0, done_configuring must be high at capture.
  - Any violation sets term_err. term_err clears on an accepted start or on reset.
  - Requires a second NUM_ELEMENTS x TERM_W buffer holding the previous point's terms.
- Undefined: no second buffer; term_err is tied to 0.

Decomposition:
- Package scanline_term_pkg:
  - TERM_W function
  - state enum
  - term typedef (logic signed [TERM_W-1:0])
  - TERM_STEP constant (2.0 in term units)
- Sub-module term_stream_serializer:
  - holds the capture buffer, element counter and valid/ready output register;
  - load/busy interface to the FSM.

Test Plan:
- Stub generator returns terms = 5210 for all elements at k=0; start with r_0=10, angle=90, num_points=3, out_ready=1.
  - Expect 3 ack pulses, final_scanpoint only on the third.
  - Expect 192 beats carrying terms 5210, 5242, 5274.
  - Expect out_last on the last beat, then scan_done.
- Stub terms_in[n] = 1000 + n; toggle out_ready 1-0-1-0.
  - Expect out_term to equal 1000 + out_elem and stay stable during stalls.
  - Expect no beat lost or duplicated.
- Stub holds terms_ready high continuously.
  - Expect exactly one capture per point, never before the stream completes, and no ack in the cycle after ack.
- Reset deasserted-to-asserted (rst=0) mid-STREAM at beat 20.
  - Expect all outputs 0 next cycle.
  - Expect a fresh start to run cleanly.
- num_points=0.
  - Expect a single point with final_scanpoint on its ack.
- With SCANLINE_TERM_CHECK_EN defined, the stub adds 31 instead of 32 at k=1 for element 7.
  - Expect term_err set after the second capture and held until the next start.
